aes_dec_ctrl: RTL and testbench
===============================

Name: aes_dec_ctrl

Overview:
Iterative AES inverse-cipher round controller; one decryption round per clock.
- Sequences InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns over a 128-bit state register; instantiates the existing inv_mixcol block.
- Fetches round keys from an external key store and uses a shared external InvSubBytes unit.
- Sits between the bus-side ciphertext FIFO and the plaintext output stage.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); legal values only 10, 12, 14.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  ciphertext block valid
in_ready  output  1  controller can accept a block
in_data  input  128  ciphertext; byte 0 = [127:120], column-major (bytes 4c..4c+3 = column c)
out_valid  output  1  plaintext valid
out_ready  input  1  downstream accepts plaintext
out_data  output  128  plaintext, same byte order
busy  output  1  high in ROUND or FINAL
rk_idx  output  4  round-key index requested
rk  input  128  round key for rk_idx, valid combinationally in the same cycle
sb_in  output  128  state to the shared InvSubBytes unit
sb_out  input  128  InvSubBytes(sb_in), combinational, same cycle

Behaviour:
Clock and reset: single clock clk; reset rst_n is synchronous, active-low.

Reset values (all 0): state register, round counter, out_valid, busy. FSM resets to IDLE.

Reset mid-operation: abandons the block; no output is produced.

FSM states: IDLE, ROUND, FINAL, DONE.

IDLE
- in_ready=1; rk_idx=NR.
- On in_valid: state <= in_data ^ rk; rnd <= NR-1; go to ROUND.

ROUND
- rk_idx=rnd.
- Next state = inv_mixcol(sb_out ^ rk).
- rnd decrements; when rnd==1, go to FINAL.

FINAL
- rk_idx=0.
- Next state = sb_out ^ rk; go to DONE.

DONE
- out_valid=1; out_data=state register; rk_idx=0.
- On out_ready: go to IDLE. out_valid deasserts the next cycle.
- out_data holds stable while out_valid=1 and out_ready=0; no limit on stall length.

sb_in (all states) = InvShiftRows(state register).
- Output byte (row r, col c) = input byte (r, (c−r) mod 4); byte index = 4c+r.

in_ready: high only in IDLE. Blocks are never accepted in DONE, even with out_ready high in the same cycle.

Latency and throughput (NR=10):
- Acceptance edge at cycle 0; ROUND occupies cycles 1–9; FINAL is cycle 10; out_valid is high from cycle 11.
- Minimum spacing between accepted blocks: NR+2 cycles.

Changes on in_data or in_valid outside IDLE are ignored.

All datapath operations are XOR/wiring; no arithmetic carries. The round counter is 4 bits and never wraps: it exits to FINAL at rnd==1.

Decomposition:
Shared package aes_pkg holds:
- constants AES_BLK_W=128 and RK_IDX_W=4;
- the FSM state enum;
- function inv_shift_rows (128→128), reused by any future pipelined decryptor.

Sub-module: inv_mixcol, instantiated once on (sb_out ^ rk). No other sub-modules.

Test Plan:
1. FIPS-197 C.1. Bench key-schedule and InvSbox models, key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a. Required: rk_idx=10 at acceptance (rk=13111d7fe3944a17f307a78b4d2b30c5), then 9,8,…,1,0; out_valid at cycle 11; out_data 00112233445566778899aabbccddeeff.
2. Output backpressure. Hold out_ready=0 for 20 cycles after out_valid. Required: out_data stable, in_ready=0 throughout; release → IDLE next cycle, in_ready=1.
3. Back-to-back blocks. Hold in_valid=1 with two ciphertexts, out_ready=1. Required: second acceptance exactly 12 cycles after the first; both plaintexts correct and in order.
4. Mid-operation reset. Assert rst_n=0 for one cycle at cycle 5. Required: next cycle out_valid=0, busy=0, in_ready=1, rk_idx=10; no spurious output.
5. NR=14 build (AES-256 FIPS-197 C.3 ct 8ea2b7ca516745bfeafc49904b496089). Required: rk_idx 14→0; out_valid at cycle 15; out_data 00112233445566778899aabbccddeeff.
6. Ignored input. Toggle in_data and in_valid during ROUND. Required: result identical to scenario 1; in_ready stays 0 until IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, decryptor FSM states and the InvShiftRows byte permutation
package aes_pkg;
   localparam int AES_BLK_W = 128;
   localparam int RK_IDX_W  = 4;
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} dec_state_e;
   // byte index 4c+r sits at [127-8*(4c+r) -: 8]; row r rotates right by r columns
   function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
      logic [AES_BLK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[AES_BLK_W-1-8*(4*c+r) -: 8] = s[AES_BLK_W-1-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction
endpackage

// File: rtl/aes_dec_ctrl_if.sv
// aes_dec_ctrl_if: ciphertext in / plaintext out handshakes plus key-store and InvSubBytes side buses
//   slave  : the round controller (drives in_ready, out_*, busy, rk_idx, sb_in)
//   master : the surroundings (drive in_valid/in_data, out_ready, rk, sb_out)
interface aes_dec_ctrl_if;
   import aes_pkg::*;
   logic                 in_valid;
   logic                 in_ready;
   logic [AES_BLK_W-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [AES_BLK_W-1:0] out_data;
   logic                 busy;
   logic [RK_IDX_W-1:0]  rk_idx;
   logic [AES_BLK_W-1:0] rk;
   logic [AES_BLK_W-1:0] sb_in;
   logic [AES_BLK_W-1:0] sb_out;
   modport slave  (input  in_valid, in_data, out_ready, rk, sb_out,
                   output in_ready, out_valid, out_data, busy, rk_idx, sb_in);
   modport master (output in_valid, in_data, out_ready, rk, sb_out,
                   input  in_ready, out_valid, out_data, busy, rk_idx, sb_in);
endinterface

// File: rtl/inv_mixcol.sv
// inv_mixcol: AES InvMixColumns over all four columns of a 128-bit state
//   data_i : state in, byte 4c+r = row r of column c
//   data_o : InvMixColumns(data_i)
module inv_mixcol
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] data_i,
   output logic [AES_BLK_W-1:0] data_o
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   // GF(2^8) multiply by a 4-bit constant built from x, x^2, x^3 terms
   function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] m);
      logic [7:0] b2, b4, b8;
      b2 = xt(b);
      b4 = xt(b2);
      b8 = xt(b4);
      return (m[3] ? b8 : 8'h00) ^ (m[2] ? b4 : 8'h00) ^ (m[1] ? b2 : 8'h00) ^ (m[0] ? b : 8'h00);
   endfunction
   always_comb begin
      data_o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            data_o[AES_BLK_W-1-8*(4*c+r) -: 8] =
               mul(data_i[AES_BLK_W-1-8*(4*c+r) -: 8], 4'd14) ^
               mul(data_i[AES_BLK_W-1-8*(4*c+(r+1)%4) -: 8], 4'd11) ^
               mul(data_i[AES_BLK_W-1-8*(4*c+(r+2)%4) -: 8], 4'd13) ^
               mul(data_i[AES_BLK_W-1-8*(4*c+(r+3)%4) -: 8], 4'd9);
   end
endmodule

// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: iterative AES inverse-cipher round controller, one round per clock
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of aes_dec_ctrl_if (ciphertext in, plaintext out,
//                round-key index/key, shared InvSubBytes in/out, busy)
//   NR         : rounds, 10/12/14 for AES-128/192/256
module aes_dec_ctrl
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input logic          clk,
   input logic          rst_n,
   aes_dec_ctrl_if.slave bus
);
   dec_state_e           fsm_q;
   logic [AES_BLK_W-1:0] state_q, state_d, ark, mix;
   logic [RK_IDX_W-1:0]  rnd_q;
   logic                 out_valid_q, busy_q;
   assign ark = bus.sb_out ^ bus.rk;
   inv_mixcol u_imc (.data_i(ark), .data_o(mix));
   assign state_d = fsm_q == IDLE  ? (bus.in_valid ? bus.in_data ^ bus.rk : state_q) :
                    fsm_q == ROUND ? mix :
                    fsm_q == FINAL ? ark : state_q;
   assign bus.sb_in     = inv_shift_rows(state_q);
   assign bus.rk_idx    = fsm_q == IDLE ? RK_IDX_W'(NR) : fsm_q == ROUND ? rnd_q : '0;
   assign bus.in_ready  = fsm_q == IDLE;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = state_q;
   assign bus.busy      = busy_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         rnd_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         case (fsm_q)
            IDLE: if (bus.in_valid) begin
               rnd_q  <= RK_IDX_W'(NR - 1);
               busy_q <= 1'b1;
               fsm_q  <= ROUND;
            end
            ROUND: begin
               rnd_q <= rnd_q - RK_IDX_W'(1);
               if (rnd_q == RK_IDX_W'(1)) fsm_q <= FINAL;
            end
            FINAL: begin
               busy_q      <= 1'b0;
               out_valid_q <= 1'b1;
               fsm_q       <= DONE;
            end
            DONE: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               fsm_q       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: scoreboard bench for aes_dec_ctrl (NR=10 and NR=14 instances) against a byte-level AES model
module tb_aes_dec_ctrl;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_dec_ctrl_if if10 ();
   aes_dec_ctrl_if if14 ();
   aes_dec_ctrl #(.NR(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(if10.slave));
   aes_dec_ctrl #(.NR(14)) u14 (.clk(clk), .rst_n(rst_n), .bus(if14.slave));

   logic [7:0]    sbx [256];
   logic [7:0]    isbx[256];
   logic [1919:0] ks  [2];
   logic          iv  [2];
   logic          ordy[2];
   logic [127:0]  idata[2];
   logic          ir  [2];
   logic          ov  [2];
   logic          bsy [2];
   logic [127:0]  od  [2];
   logic [3:0]    ridx[2];
   logic [127:0]  q0[$];
   logic [127:0]  q1[$];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] x);
      logic [127:0] o;
      for (int b = 0; b < 16; b++) o[127-8*b -: 8] = isbx[x[127-8*b -: 8]];
      return o;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
   endfunction

   // FIPS-197 key expansion; round key r lands at [1919-128r -: 128]
   function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
      logic [31:0]   w[60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] o;
      int            nk;
      nk = nr - 6;
      rc = 8'h01;
      o  = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) o[1919-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return o;
   endfunction

   // textbook InvCipher on a 16-byte array
   function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [1919:0] k, input int nr);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [127:0] o;
      for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ k[1919-128*nr-8*b -: 8];
      for (int rd = nr - 1; rd >= 0; rd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c-r+4)%4)+r];
         for (int b = 0; b < 16; b++) t[b] = isbx[t[b]] ^ k[1919-128*rd-8*b -: 8];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c+r] = rd == 0 ? t[4*c+r] :
                  gmul(t[4*c+r], 8'd14) ^ gmul(t[4*c+(r+1)%4], 8'd11) ^
                  gmul(t[4*c+(r+2)%4], 8'd13) ^ gmul(t[4*c+(r+3)%4], 8'd9);
      end
      for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
      return o;
   endfunction

   assign if10.in_valid  = iv[0];
   assign if10.in_data   = idata[0];
   assign if10.out_ready = ordy[0];
   assign if10.rk        = ks[0][1919-128*if10.rk_idx -: 128];
   assign if10.sb_out    = inv_sub(if10.sb_in);
   assign ir[0]   = if10.in_ready;
   assign ov[0]   = if10.out_valid;
   assign bsy[0]  = if10.busy;
   assign od[0]   = if10.out_data;
   assign ridx[0] = if10.rk_idx;
   assign if14.in_valid  = iv[1];
   assign if14.in_data   = idata[1];
   assign if14.out_ready = ordy[1];
   assign if14.rk        = ks[1][1919-128*if14.rk_idx -: 128];
   assign if14.sb_out    = inv_sub(if14.sb_in);
   assign ir[1]   = if14.in_ready;
   assign ov[1]   = if14.out_valid;
   assign bsy[1]  = if14.busy;
   assign od[1]   = if14.out_data;
   assign ridx[1] = if14.rk_idx;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   task automatic push(input int d, input logic [127:0] e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   function automatic int qsize(input int d);
      return d == 0 ? q0.size() : q1.size();
   endfunction

   always @(negedge clk)
      if (rst_n && ov[0] && ordy[0]) begin
         if (q0.size() == 0) fail_now($sformatf("spurious_out10 got %h required none", od[0]));
         else chk("plaintext10", od[0], q0.pop_front());
      end

   always @(negedge clk)
      if (rst_n && ov[1] && ordy[1]) begin
         if (q1.size() == 0) fail_now($sformatf("spurious_out14 got %h required none", od[1]));
         else chk("plaintext14", od[1], q1.pop_front());
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input logic [127:0] ct, input logic [127:0] exp, input bit rr);
      bit ok;
      ok = 1'b0;
      iv[d] = 1'b1;
      idata[d] = ct;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (ir[d]) ok = 1'b1;
         else begin
            tick();
            if (rr) ordy[d] = 1'($urandom);
         end
      end
      if (!ok) begin
         fail_now("accept_timeout");
         iv[d] = 1'b0;
         return;
      end
      @(posedge clk);
      push(d, exp);
      #1;
      iv[d] = 1'b0;
      if (rr) ordy[d] = 1'($urandom);
   endtask

   task automatic drain(input int d, input bit rr);
      int n;
      n = 0;
      while (qsize(d) > 0 && n < 400) begin
         tick();
         if (rr) ordy[d] = 1'($urandom);
         n++;
      end
      if (qsize(d) > 0) fail_now("drain_timeout");
      ordy[d] = 1'b1;
   endtask

   task automatic known(input int d, input int nr, input logic [127:0] ct, input logic [255:0] key);
      ks[d] = expand(key, nr);
      ordy[d] = 1'b1;
      iv[d] = 1'b1;
      idata[d] = ct;
      @(negedge clk);
      chk("idle_in_ready", 128'(ir[d]), 128'(1));
      chk("rk_idx_accept", 128'(ridx[d]), 128'(nr));
      @(posedge clk);
      push(d, PT);
      #1;
      iv[d] = 1'b0;
      for (int k = 1; k <= nr; k++) begin
         @(negedge clk);
         chk($sformatf("rk_idx_cycle%0d", k), 128'(ridx[d]), 128'(nr - k));
         chk("no_early_valid", 128'(ov[d]), 128'(0));
      end
      @(negedge clk);
      chk("out_valid_latency", 128'(ov[d]), 128'(1));
      tick();
      drain(d, 1'b0);
   endtask

   initial begin
      logic [7:0]   inv, s;
      logic [127:0] a, b, e;
      logic [255:0] key;
      time          t0, t1;
      bit           ok;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256 && x != 0; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sbx[x] = s;
         isbx[s] = 8'(x);
      end
      ks[0] = expand(KEY1, 10);
      ks[1] = expand(KEY3, 14);
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0;
         ordy[d] = 1'b1;
         idata[d] = '0;
      end
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 128'(ov[0]), 128'(0));
      chk("rst_busy", 128'(bsy[0]), 128'(0));
      chk("rst_in_ready", 128'(ir[0]), 128'(1));
      chk("rst_state", od[0], 128'(0));
      chk("rst_rk_idx10", 128'(ridx[0]), 128'(10));
      chk("rst_rk_idx14", 128'(ridx[1]), 128'(14));
      tick();

      known(0, 10, CT1, KEY1);

      // output backpressure
      ordy[0] = 1'b0;
      a = {$urandom, $urandom, $urandom, $urandom};
      e = model_dec(a, ks[0], 10);
      send(0, a, e, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = ov[0];
      end
      if (!ok) fail_now("bp_valid_timeout");
      for (int i = 0; i < 20; i++) begin
         chk("bp_data_stable", od[0], e);
         chk("bp_in_ready_low", 128'(ir[0]), 128'(0));
         chk("bp_valid_held", 128'(ov[0]), 128'(1));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      ordy[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 128'(ir[0]), 128'(1));
      chk("bp_release_valid", 128'(ov[0]), 128'(0));
      tick();

      // back-to-back acceptance
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      iv[0] = 1'b1;
      idata[0] = a;
      do @(negedge clk); while (!ir[0]);
      @(posedge clk);
      t0 = $time;
      push(0, model_dec(a, ks[0], 10));
      #1;
      idata[0] = b;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = ir[0];
      end
      @(posedge clk);
      t1 = $time;
      push(0, model_dec(b, ks[0], 10));
      #1;
      iv[0] = 1'b0;
      chk("b2b_spacing", 128'((t1 - t0) / 10), 128'(12));
      drain(0, 1'b0);

      // reset while a block is in flight
      a = {$urandom, $urandom, $urandom, $urandom};
      send(0, a, model_dec(a, ks[0], 10), 1'b0);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      q0.delete();
      @(negedge clk);
      chk("mid_rst_out_valid", 128'(ov[0]), 128'(0));
      chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
      chk("mid_rst_in_ready", 128'(ir[0]), 128'(1));
      chk("mid_rst_rk_idx", 128'(ridx[0]), 128'(10));
      repeat (20) tick();
      @(negedge clk);
      chk("mid_rst_no_output", 128'(ov[0]), 128'(0));
      tick();

      // input changes during ROUND are ignored
      iv[0] = 1'b1;
      idata[0] = CT1;
      @(negedge clk);
      @(posedge clk);
      push(0, PT);
      #1;
      for (int k = 1; k <= 9; k++) begin
         iv[0] = 1'($urandom);
         idata[0] = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("ignore_in_ready", 128'(ir[0]), 128'(0));
         tick();
      end
      iv[0] = 1'b0;
      drain(0, 1'b0);

      known(1, 14, CT3, KEY3);

      // randomized traffic, new key per instance
      for (int d = 0; d < 2; d++) begin
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         ks[d] = expand(key, d == 0 ? 10 : 14);
         for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) begin
               tick();
               ordy[d] = 1'($urandom);
            end
            a = {$urandom, $urandom, $urandom, $urandom};
            send(d, a, model_dec(a, ks[d], d == 0 ? 10 : 14), 1'b1);
         end
         drain(d, 1'b1);
         tick();
      end

      chk("q10_empty", 128'(q0.size()), 128'(0));
      chk("q14_empty", 128'(q1.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end
endmodule
